// File: rtl/tensor_core_scheduler.sv
// Round-robin arbiter that shares one small tensor core between two requesters,
// sequencing load/start/wait and returning the captured 3x3 result.
module tensor_core_scheduler #(
  parameter int BUS_WIDTH    = 8,
  parameter int CORE_LATENCY = 5,
  parameter int MAT_BITS     = 9 * BUS_WIDTH
) (
  input  logic                  tensor_core_clock,
  input  logic                  tensor_core_reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [3:0]            req_op,
  input  logic [2*MAT_BITS-1:0] req_a,
  input  logic [2*MAT_BITS-1:0] req_b,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [MAT_BITS-1:0]   resp_data,
  output logic                  busy,
  output logic                  core_write_enable,
  output logic                  core_start,
  output logic [1:0]            core_operation_select,
  output logic [MAT_BITS-1:0]   core_input1,
  output logic [MAT_BITS-1:0]   core_input2,
  input  logic [MAT_BITS-1:0]   core_output
);

  localparam int CW = $clog2(CORE_LATENCY);
  localparam logic [CW-1:0] LAST = CW'(CORE_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, RESP} state_t;

  state_t        state, state_next;
  logic          rr_last;
  logic          owner;
  logic          grant;
  logic          accept;
  logic [CW-1:0] cnt;

  // Single requester wins outright; on contention the one not served last wins.
  always_comb begin
    grant = 1'b0;
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~rr_last;
      default: grant = 1'b0;
    endcase
  end

  always_comb begin
    state_next        = state;
    req_ready         = '0;
    resp_valid        = '0;
    core_write_enable = 1'b0;
    core_start        = 1'b0;
    accept            = 1'b0;
    busy              = (state != IDLE);
    case (state)
      IDLE: begin
        req_ready[grant] = req_valid[grant] & ~tensor_core_reset;
        accept           = req_valid[grant];
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        core_write_enable = 1'b1;
        state_next        = START;
      end
      START: begin
        core_start = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt == LAST) state_next = RESP;
      end
      RESP: begin
        resp_valid[owner] = 1'b1;
        if (resp_ready[owner]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge tensor_core_clock or posedge tensor_core_reset) begin
    if (tensor_core_reset) begin
      state                 <= IDLE;
      rr_last               <= 1'b1;
      owner                 <= 1'b0;
      cnt                   <= '0;
      core_input1           <= '0;
      core_input2           <= '0;
      core_operation_select <= '0;
      resp_data             <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        core_input1           <= grant ? req_a[2*MAT_BITS-1:MAT_BITS] : req_a[MAT_BITS-1:0];
        core_input2           <= grant ? req_b[2*MAT_BITS-1:MAT_BITS] : req_b[MAT_BITS-1:0];
        core_operation_select <= grant ? req_op[3:2] : req_op[1:0];
        owner                 <= grant;
        rr_last               <= grant;
      end
      // Counter wraps to zero on capture, so it is ready for the next WAIT.
      if (state == WAIT) begin
        if (cnt == LAST) begin
          cnt       <= '0;
          resp_data <= core_output;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/tensor_core_scheduler.md
Name: tensor_core_scheduler

Overview:
Two-port round-robin scheduler that shares one small_tensor_core (3x3 signed 8-bit matmul / add / relu) between two requesters.
It accepts a command (operands plus operation) over a valid/ready handshake and sequences the core through its load/start protocol.
It waits a fixed compute latency, captures the 3x3 result and returns it to the originating requester over a valid/ready response channel.
It sits between the CPU-side command sources and the tensor core datapath.

Parameters:
BUS_WIDTH, 8, bits per matrix element (signed, two's complement).
CORE_LATENCY, 5, tensor_core_clock cycles from the core_start cycle's end until core_output is complete (must be >= 5).
MAT_BITS, 9*BUS_WIDTH, width of a packed 3x3 matrix; element [r][c] at bits [(3*r+c)*BUS_WIDTH +: BUS_WIDTH].

Ports:
tensor_core_clock  in  1  sole clock, all state on posedge
tensor_core_reset  in  1  asynchronous, active-high reset
req_valid  in  2  bit i: requester i has a command
req_ready  out  2  bit i: scheduler accepts requester i this cycle
req_op  in  2x2  bits [2i+1:2i]: operation; 00 matmul, 01 add, 10/11 relu
req_a  in  2xMAT_BITS  requester i operand 1 (A)
req_b  in  2xMAT_BITS  requester i operand 2 (B)
resp_valid  out  2  bit i: result for requester i is valid
resp_ready  in  2  bit i: requester i takes the result
resp_data  out  MAT_BITS  captured result, shared by both requesters
busy  out  1  high in every state except IDLE
core_write_enable  out  1  to tensor_core_register_file_write_enable
core_start  out  1  to should_start_tensor_core
core_operation_select  out  2  to operation_select
core_input1  out  MAT_BITS  to tensor_core_input1
core_input2  out  MAT_BITS  to tensor_core_input2
core_output  in  MAT_BITS  from tensor_core_output

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_last=1 (requester 0 wins first), wait counter=0.
  - All outputs 0: req_ready, resp_valid, resp_data, core_* and busy.
- States: IDLE -> LOAD -> START -> WAIT -> RESP -> IDLE.
- IDLE, grant select:
  - Only one requester valid: that one is granted.
  - Both valid: the one that is not rr_last is granted.
  - req_ready[grant] = req_valid[grant] (combinational, IDLE only); the other req_ready bit is 0.
- IDLE, accept (valid&ready at the edge):
  - Latch req_a/req_b/req_op into core_input1/core_input2/core_operation_select.
  - Store owner=grant and set rr_last=grant, then go to LOAD.
- LOAD (1 cycle): core_write_enable=1. This resets the core counter.
- START (1 cycle): core_start=1, core_write_enable=0.
- WAIT (CORE_LATENCY cycles): counter counts 0..CORE_LATENCY-1. On the edge where counter==CORE_LATENCY-1, capture core_output into resp_data and go to RESP.
- RESP:
  - resp_valid[owner]=1 is held stable with resp_data until resp_ready[owner]. Then resp_valid returns to 0 and the state goes to IDLE.
  - resp_ready on the non-owner bit is ignored.
- Timing from accept cycle 0: LOAD in cycle 1, START in cycle 2, WAIT in cycles 3..2+CORE_LATENCY, resp_valid first high in cycle 3+CORE_LATENCY (8 with the default).
- Back-to-back commands: the earliest next accept is in the IDLE cycle after the response handshake. There is no overlap of commands.
- Operand registers and core_operation_select hold their values from accept until the next accept. resp_data holds until the next capture.
- Requests that arrive while busy get req_ready=0 and wait; the scheduler never drops a request.
- Arithmetic is done entirely in the core. The scheduler passes data through without modifying it.
- Reset mid-operation (any state) aborts the command with no response. The requester must reissue it.

Test Plan:
1. Req0 matmul: A=identity, B=[1..9] -> resp_valid[0] in cycle 8 after accept, resp_data=[1..9]. core_write_enable is high in cycle 1 only and core_start in cycle 2 only.
2. Req1 add: A=all 5, B=all -3 -> resp_valid[1], resp_data all 2. resp_valid[0] stays 0 throughout.
3. Both valid every cycle, each with 3 commands -> grant order 0,1,0,1,0,1. No requester gets two grants in a row while the other is waiting.
4. Relu op=10: A=[-1,2,-3,4,-5,6,-7,8,-128] -> [0,2,0,4,0,6,0,8,0]. Hold resp_ready[0]=0 for 10 cycles -> resp_valid and resp_data stable the whole time, busy=1. The handshake then returns the scheduler to IDLE.
5. Assert tensor_core_reset in WAIT cycle 2 -> all outputs 0 immediately, with no resp_valid. After release, a new req0 command completes normally and req0 wins a simultaneous request.
6. Req1 valid while req0's command is in flight -> req_ready[1]=0 until IDLE. Req1 is then accepted in the IDLE cycle after req0's response handshake.
